// File: rtl/mdu_iterative.sv
// mdu_iterative: E-stage multiply/divide unit with architectural HI/LO.
// Each accepted mult/multu/div/divu result is computed on the accept edge
// and held in res_hi/res_lo. A busy countdown then stalls the pipeline
// before the result is committed to HI/LO. mthi/mtlo write HI/LO directly.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   mdu_op[3:0] - operation code (0000 mult .. 0111 mtlo, others none)
//   start       - launch mult/multu/div/divu this cycle
//   req         - CP0 flush; blocks a new accept or mthi/mtlo this cycle
//   src_a/src_b - forwarded rs/rt operands
//   busy        - an operation is in flight (registered)
//   mdu_out     - HI for mfhi, LO for mflo, else 0 (combinational)
//
// Build option: MDU_DIVZERO_HOLD_EN
//   defined   - divide by zero keeps HI/LO unchanged at completion
//   undefined - divide by zero writes hi=src_a, lo=0xFFFFFFFF
module mdu_iterative #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  mdu_op,
  input  logic        start,
  input  logic        req,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic [31:0] mdu_out
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;

  localparam logic [3:0] OP_MULT  = 4'b0000;
  localparam logic [3:0] OP_MULTU = 4'b0001;
  localparam logic [3:0] OP_DIV   = 4'b0010;
  localparam logic [3:0] OP_DIVU  = 4'b0011;
  localparam logic [3:0] OP_MFHI  = 4'b0100;
  localparam logic [3:0] OP_MFLO  = 4'b0101;
  localparam logic [3:0] OP_MTHI  = 4'b0110;
  localparam logic [3:0] OP_MTLO  = 4'b0111;

  typedef enum logic {ST_IDLE, ST_BUSY} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [DW-1:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
`ifdef MDU_DIVZERO_HOLD_EN
  logic          hold_q, hold_d;
`endif

  logic                 accept;
  logic                 is_div;
  logic                 div_zero;
  logic [DW-1:0]        b_safe;
  logic signed [63:0]   a_s64, b_s64;
  logic signed [DW:0]   a_s33, b_s33;
  logic [DW-1:0]        calc_hi, calc_lo;

  assign accept   = start & ~req & (state_q == ST_IDLE) & (mdu_op[3:2] == 2'b00);
  assign is_div   = mdu_op[1];
  assign div_zero = (src_b == '0);
  // Divisor forced nonzero so the divider never sees 0; the zero case is muxed out.
  assign b_safe   = div_zero ? DW'(1) : src_b;

  assign a_s64 = {{32{src_a[31]}}, src_a};
  assign b_s64 = {{32{src_b[31]}}, src_b};
  // 33-bit signed divide: 0x80000000 / -1 yields +2^31, whose low word is 0x80000000.
  assign a_s33 = {src_a[31], src_a};
  assign b_s33 = {b_safe[31], b_safe};

  // Operation result, captured into res_hi/res_lo on accept.
  always_comb begin
    calc_hi = '0;
    calc_lo = '0;
    unique case (mdu_op[1:0])
      2'b00: {calc_hi, calc_lo} = a_s64 * b_s64;
      2'b01: {calc_hi, calc_lo} = {32'b0, src_a} * {32'b0, src_b};
      2'b10: begin
        calc_lo = DW'(a_s33 / b_s33);
        calc_hi = DW'(a_s33 % b_s33);
      end
      default: begin
        calc_lo = src_a / b_safe;
        calc_hi = src_a % b_safe;
      end
    endcase
`ifndef MDU_DIVZERO_HOLD_EN
    if (is_div && div_zero) begin
      calc_hi = src_a;
      calc_lo = '1;
    end
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
`ifdef MDU_DIVZERO_HOLD_EN
      hold_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
`ifdef MDU_DIVZERO_HOLD_EN
      hold_q   <= hold_d;
`endif
    end
  end

  // Next-state: accept / direct HI-LO writes when idle, countdown and commit when busy.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
`ifdef MDU_DIVZERO_HOLD_EN
    hold_d   = hold_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          res_hi_d = calc_hi;
          res_lo_d = calc_lo;
          cnt_d    = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
          state_d  = ST_BUSY;
`ifdef MDU_DIVZERO_HOLD_EN
          hold_d   = is_div & div_zero;
`endif
        end else if (!req && mdu_op == OP_MTHI) begin
          hi_d = src_a;
        end else if (!req && mdu_op == OP_MTLO) begin
          lo_d = src_a;
        end
      end
      ST_BUSY: begin
        if (cnt_q == CW'(1)) begin
`ifdef MDU_DIVZERO_HOLD_EN
          if (!hold_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
          end
          hold_d = 1'b0;
`else
          hi_d = res_hi_q;
          lo_d = res_lo_q;
`endif
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q == ST_BUSY);

  // HI/LO read port for the E-stage result mux.
  always_comb begin
    mdu_out = '0;
    if (mdu_op == OP_MFHI)      mdu_out = hi_q;
    else if (mdu_op == OP_MFLO) mdu_out = lo_q;
  end

endmodule

// File: tb/tb_mdu_iterative.sv
// Scoreboard bench for mdu_iterative: stimulus pushes expected read values
// and expected busy-pulse lengths; a monitor pops and compares them.
module tb_mdu_iterative;

  localparam logic [3:0] OP_MULT  = 4'b0000;
  localparam logic [3:0] OP_MULTU = 4'b0001;
  localparam logic [3:0] OP_DIV   = 4'b0010;
  localparam logic [3:0] OP_DIVU  = 4'b0011;
  localparam logic [3:0] OP_MFHI  = 4'b0100;
  localparam logic [3:0] OP_MFLO  = 4'b0101;
  localparam logic [3:0] OP_MTHI  = 4'b0110;
  localparam logic [3:0] OP_MTLO  = 4'b0111;
  localparam logic [3:0] OP_NONE  = 4'b1111;

  typedef struct {
    string       name;
    logic [31:0] val;
  } rd_exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  mdu_op;
  logic        start;
  logic        req;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic [31:0] mdu_out;

  int total = 0;
  int bad   = 0;

  rd_exp_t q_rd[$];
  int      q_bz[$];

  always #5 clk = ~clk;

  mdu_iterative #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .mdu_op  (mdu_op),
    .start   (start),
    .req     (req),
    .src_a   (src_a),
    .src_b   (src_b),
    .busy    (busy),
    .mdu_out (mdu_out)
  );

  // Monitor: checks every mfhi/mflo read and every completed busy pulse.
  initial begin : monitor
    int      run;
    rd_exp_t e;
    int      len;
    run = 0;
    forever begin
      @(negedge clk);
      if (mdu_op == OP_MFHI || mdu_op == OP_MFLO) begin
        total++;
        if (q_rd.size() == 0) begin
          bad++;
          $display("FAIL unexpected_read: mdu_out=%h with no expectation", mdu_out);
        end else begin
          e = q_rd.pop_front();
          if (mdu_out !== e.val) begin
            bad++;
            $display("FAIL %s: got %h expected %h", e.name, mdu_out, e.val);
          end
        end
      end
      if (busy === 1'b1) begin
        run++;
      end else if (run != 0) begin
        total++;
        if (q_bz.size() == 0) begin
          bad++;
          $display("FAIL unexpected_busy: pulse of %0d cycles", run);
        end else begin
          len = q_bz.pop_front();
          if (run != len) begin
            bad++;
            $display("FAIL busy_len: got %0d cycles expected %0d", run, len);
          end
        end
        run = 0;
      end
    end
  end

  // One-cycle issue of an operation; returns 1 time unit after the edge.
  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic st, input logic rq);
    mdu_op = op;
    src_a  = a;
    src_b  = b;
    start  = st;
    req    = rq;
    @(posedge clk);
    #1;
    mdu_op = OP_NONE;
    start  = 1'b0;
    req    = 1'b0;
  endtask

  task automatic rd(input logic [3:0] op, input string name, input logic [31:0] v);
    rd_exp_t e;
    e.name = name;
    e.val  = v;
    q_rd.push_back(e);
    mdu_op = op;
    @(posedge clk);
    #1;
    mdu_op = OP_NONE;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (busy) begin
      bad++;
      $display("FAIL idle_timeout: busy=%b after %0d cycles", busy, n);
    end
  endtask

  initial begin : stim
    rst_n  = 1'b0;
    mdu_op = OP_NONE;
    start  = 1'b0;
    req    = 1'b0;
    src_a  = '0;
    src_b  = '0;
    repeat (2) @(posedge clk);
    #1;
    rd(OP_MFHI, "rst_hold_hi", 32'h0);
    rst_n = 1'b1;
    rd(OP_MFHI, "rst_hi", 32'h0);
    rd(OP_MFLO, "rst_lo", 32'h0);

    // mult -2 * 3
    q_bz.push_back(5);
    drive(OP_MULT, 32'hFFFF_FFFE, 32'h3, 1'b1, 1'b0);
    wait_idle();
    rd(OP_MFHI, "mult_hi", 32'hFFFF_FFFF);
    rd(OP_MFLO, "mult_lo", 32'hFFFF_FFFA);

    // multu max * max
    q_bz.push_back(5);
    drive(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    wait_idle();
    rd(OP_MFHI, "multu_hi", 32'hFFFF_FFFE);
    rd(OP_MFLO, "multu_lo", 32'h0000_0001);

    // div -7 / 2
    q_bz.push_back(10);
    drive(OP_DIV, 32'hFFFF_FFF9, 32'h2, 1'b1, 1'b0);
    wait_idle();
    rd(OP_MFLO, "div_lo", 32'hFFFF_FFFD);
    rd(OP_MFHI, "div_hi", 32'hFFFF_FFFF);

    // div overflow corner
    q_bz.push_back(10);
    drive(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    wait_idle();
    rd(OP_MFLO, "divovf_lo", 32'h8000_0000);
    rd(OP_MFHI, "divovf_hi", 32'h0);

    // divu 100 / 7
    q_bz.push_back(10);
    drive(OP_DIVU, 32'd100, 32'd7, 1'b1, 1'b0);
    wait_idle();
    rd(OP_MFLO, "divu_lo", 32'd14);
    rd(OP_MFHI, "divu_hi", 32'd2);

    // req blocks accept and mthi
    drive(OP_MULT, 32'd4, 32'd5, 1'b1, 1'b1);
    drive(OP_MTHI, 32'hDEAD, 32'h0, 1'b0, 1'b1);
    repeat (8) @(posedge clk);
    #1;
    rd(OP_MFHI, "req_hi", 32'd2);
    rd(OP_MFLO, "req_lo", 32'd14);

    // mthi / mtlo visible next cycle
    drive(OP_MTHI, 32'h1234, 32'h0, 1'b0, 1'b0);
    rd(OP_MFHI, "mthi", 32'h1234);
    drive(OP_MTLO, 32'h5678, 32'h0, 1'b0, 1'b0);
    rd(OP_MFLO, "mtlo", 32'h5678);

    // start while busy ignored, then back-to-back accept in cycle N+1
    q_bz.push_back(5);
    drive(OP_MULT, 32'd2, 32'd3, 1'b1, 1'b0);
    drive(OP_MULTU, 32'd9, 32'd9, 1'b1, 1'b0);
    wait_idle();
    q_bz.push_back(5);
    drive(OP_MULTU, 32'd7, 32'd7, 1'b1, 1'b0);
    rd(OP_MFLO, "busy_old_lo", 32'd6);
    rd(OP_MFHI, "busy_old_hi", 32'd0);
    wait_idle();
    rd(OP_MFLO, "b2b_lo", 32'h31);
    rd(OP_MFHI, "b2b_hi", 32'h0);

    // divide by zero
    drive(OP_MTHI, 32'h55, 32'h0, 1'b0, 1'b0);
    drive(OP_MTLO, 32'h55, 32'h0, 1'b0, 1'b0);
    q_bz.push_back(10);
    drive(OP_DIVU, 32'h10, 32'h0, 1'b1, 1'b0);
    wait_idle();
`ifdef MDU_DIVZERO_HOLD_EN
    rd(OP_MFHI, "divz_hi", 32'h55);
    rd(OP_MFLO, "divz_lo", 32'h55);
`else
    rd(OP_MFHI, "divz_hi", 32'h10);
    rd(OP_MFLO, "divz_lo", 32'hFFFF_FFFF);
`endif

    // reset in busy cycle 4 of divu 100/7
    q_bz.push_back(4);
    drive(OP_DIVU, 32'd100, 32'd7, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rd(OP_MFHI, "rst_mid_hi", 32'h0);
    rd(OP_MFLO, "rst_mid_lo", 32'h0);
    rst_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    rd(OP_MFHI, "post_rst_hi", 32'h0);
    rd(OP_MFLO, "post_rst_lo", 32'h0);

    repeat (3) @(posedge clk);
    total++;
    if (q_rd.size() != 0 || q_bz.size() != 0) begin
      bad++;
      $display("FAIL drain: rd_left=%0d busy_left=%0d expected 0/0", q_rd.size(), q_bz.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
